// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared constants and helpers for the pulse clock-divider slice.
//   DIV_A_DEF, DIV_B_DEF : default division ratios (100 and 200).
//   cnt_width()          : half-period counter width, clog2(DIV/2), minimum 1.
//   div_ok()             : true when a ratio is even and at least 2.
// -----------------------------------------------------------------------------
package pulse_pkg;

  localparam int unsigned DIV_A_DEF = 100;
  localparam int unsigned DIV_B_DEF = 200;

  // DIV = 2 gives a half period of one cycle. clog2(1) is 0, so this case is
  // clamped to keep a real 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned div);
    int unsigned half;
    half = div / 2;
    return (half <= 2) ? 1 : $clog2(half);
  endfunction

  function automatic bit div_ok(input int unsigned div);
    return (div >= 2) && ((div % 2) == 0);
  endfunction

endpackage : pulse_pkg

// File: rtl/pulse_clk_div_even.sv
// -----------------------------------------------------------------------------
// clk_div_even
// Even-ratio 50%-duty divider. It produces a registered square wave with a
// period of DIV clk_in cycles. The output first rises on the DIV/2-th rising
// edge after rst is released.
// Optional feature macro: PULSE_STROBE_EN. When it is defined, the module adds
// a one-cycle tick that is registered on the edge where clk_out rises.
// Ports:
//   clk_in  : input,  system clock, rising-edge active
//   rst     : input,  synchronous active-high reset
//   clk_out : output, registered square wave, period DIV cycles
//   tick    : output, one-cycle strobe on each clk_out rise (PULSE_STROBE_EN)
// -----------------------------------------------------------------------------
module clk_div_even
  import pulse_pkg::*;
#(
  parameter int unsigned DIV = 100
) (
  input  logic clk_in,
  input  logic rst,
`ifdef PULSE_STROBE_EN
  output logic tick,
`endif
  output logic clk_out
);

  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned W    = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  if (!div_ok(DIV)) begin : g_bad_div
    $error("clk_div_even: DIV must be even and >= 2");
  end

  logic [W-1:0] cnt;
  logic         wrap;

  assign wrap = (cnt == LAST);

  // NOTE: all state here is updated with non-blocking assignments, so every
  // flop samples the values from before the edge. This keeps clk_out and tick
  // consistent with the counter regardless of the statement order.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else if (cnt > LAST) begin
      // This state is unreachable in normal operation. It recovers from an
      // upset without disturbing the output phase.
      cnt     <= '0;
    end else begin
      cnt     <= cnt + W'(1);
    end
  end

`ifdef PULSE_STROBE_EN
  // The tick fires on the same edge that takes clk_out from 0 to 1.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= wrap && !clk_out;
    end
  end
`endif

endmodule : clk_div_even

// File: rtl/pulse.sv
// -----------------------------------------------------------------------------
// pulse
// Fixed-ratio divided-clock generator for the 100 MHz board clock. It produces
// two phase-aligned 50%-duty square waves at clk_in/DIV_A and clk_in/DIV_B.
// Both outputs come directly from flops. They are meant as data or enable
// sources and are not meant to drive clock trees.
// Optional feature macro: PULSE_STROBE_EN. When it is defined, the module adds
// tick_100 and tick_200, which are one-cycle strobes on each rising edge of
// the matching output.
// Ports:
//   clk_in      : input,  100 MHz system clock, rising-edge active
//   rst         : input,  synchronous active-high reset
//   clk_div_100 : output, square wave, period DIV_A cycles
//   clk_div_200 : output, square wave, period DIV_B cycles
//   tick_100    : output, strobe on clk_div_100 rise (PULSE_STROBE_EN)
//   tick_200    : output, strobe on clk_div_200 rise (PULSE_STROBE_EN)
// -----------------------------------------------------------------------------
module pulse
  import pulse_pkg::*;
#(
  parameter int unsigned DIV_A = DIV_A_DEF,
  parameter int unsigned DIV_B = DIV_B_DEF
) (
  input  logic clk_in,
  input  logic rst,
`ifdef PULSE_STROBE_EN
  output logic tick_100,
  output logic tick_200,
`endif
  output logic clk_div_100,
  output logic clk_div_200
);

  if (!div_ok(DIV_A)) begin : g_bad_div_a
    $error("pulse: DIV_A must be even and >= 2");
  end

  if (!div_ok(DIV_B)) begin : g_bad_div_b
    $error("pulse: DIV_B must be even and >= 2");
  end

  // Both channels start counting on the same edge after reset. This gives the
  // phase relation: every rise of the slow output lines up with a fall of the
  // fast one.
  clk_div_even #(.DIV(DIV_A)) u_div_a (
    .clk_in  (clk_in),
    .rst     (rst),
`ifdef PULSE_STROBE_EN
    .tick    (tick_100),
`endif
    .clk_out (clk_div_100)
  );

  clk_div_even #(.DIV(DIV_B)) u_div_b (
    .clk_in  (clk_in),
    .rst     (rst),
`ifdef PULSE_STROBE_EN
    .tick    (tick_200),
`endif
    .clk_out (clk_div_200)
  );

endmodule : pulse

// File: tb/tb_pulse.sv
// -----------------------------------------------------------------------------
// tb_pulse
// Directed bench for pulse. On each rising edge the expected outputs come from
// an edge-count model. The expected values are pushed into a scoreboard queue,
// then popped and compared 1 ns after the edge. Width and phase relations are
// also checked explicitly.
// -----------------------------------------------------------------------------
module tb_pulse;
  import pulse_pkg::*;

  localparam int unsigned DIV_A = DIV_A_DEF;
  localparam int unsigned DIV_B = DIV_B_DEF;
  localparam int unsigned H_A   = DIV_A / 2;
  localparam int unsigned H_B   = DIV_B / 2;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic clk_div_100;
  logic clk_div_200;
`ifdef PULSE_STROBE_EN
  logic tick_100;
  logic tick_200;
`endif

  pulse #(.DIV_A(DIV_A), .DIV_B(DIV_B)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
`ifdef PULSE_STROBE_EN
    .tick_100    (tick_100),
    .tick_200    (tick_200),
`endif
    .clk_div_100 (clk_div_100),
    .clk_div_200 (clk_div_200)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic a;
    logic b;
    logic ta;
    logic tb;
  } exp_t;

  exp_t        sb[$];
  int unsigned edges  = 0;
  int          checks   = 0;
  int          failures = 0;
  logic        prev_a = 1'b0;
  logic        prev_b = 1'b0;
  int          run_a  = 0;
  int          run_b  = 0;
  bit          armed_a = 1'b0;
  bit          armed_b = 1'b0;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edges, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edges, obs, exp);
    end
  endtask

  // Reference: after n counting edges, the output level is the parity of n/H.
  function automatic exp_t model(input int unsigned n);
    exp_t e;
    e = '0;
    if (n != 0) begin
      e.a  = ((n / H_A) % 2) == 1;
      e.b  = ((n / H_B) % 2) == 1;
      e.ta = ((n % H_A) == 0) && e.a;
      e.tb = ((n % H_B) == 0) && e.b;
    end
    return e;
  endfunction

  // One clock cycle: drive rst at negedge, push the expectation at posedge,
  // then pop it and compare 1 ns later.
  task automatic cycle(input logic r);
    exp_t e;
    @(negedge clk_in);
    rst = r;
    @(posedge clk_in);
    edges = r ? 0 : edges + 1;
    sb.push_back(model(edges));
    #1;
    e = sb.pop_front();
    check("clk_div_100", clk_div_100, e.a);
    check("clk_div_200", clk_div_200, e.b);
`ifdef PULSE_STROBE_EN
    check("tick_100", tick_100, e.ta);
    check("tick_200", tick_200, e.tb);
`endif
    // Phase: a rise of the slow output must coincide with a fall of the fast one.
    if (clk_div_200 === 1'b1 && prev_b === 1'b0) begin
      check("phase_100_low", clk_div_100, 1'b0);
      check("phase_100_was_high", prev_a, 1'b1);
    end
    // Width: every complete high or low run is exactly H cycles long.
    if (r) begin
      run_a = 0; run_b = 0; armed_a = 1'b0; armed_b = 1'b0;
    end else begin
      if (clk_div_100 !== prev_a) begin
        if (armed_a) check_int("width_100", run_a, H_A);
        armed_a = 1'b1;
        run_a   = 1;
      end else begin
        run_a++;
      end
      if (clk_div_200 !== prev_b) begin
        if (armed_b) check_int("width_200", run_b, H_B);
        armed_b = 1'b1;
        run_b   = 1;
      end else begin
        run_b++;
      end
    end
    prev_a = clk_div_100;
    prev_b = clk_div_200;
  endtask

  initial begin
    int rise_at;

    // Hold reset for 10 cycles: both outputs stay low.
    for (int i = 0; i < 10; i++) cycle(1'b1);

    // Release and run 420 cycles: this covers four periods of clk_div_100
    // and two periods of clk_div_200.
    for (int i = 0; i < 420; i++) cycle(1'b0);

    // Reset mid-run: run 74 edges, then assert rst on edge 75, while
    // clk_div_100 is high.
    cycle(1'b1);
    for (int i = 0; i < 74; i++) cycle(1'b0);
    check("pre_mid_reset_high", clk_div_100, 1'b1);
    cycle(1'b1);
    check("mid_reset_100_low", clk_div_100, 1'b0);
    check("mid_reset_200_low", clk_div_200, 1'b0);

    // After release, clk_div_100 must next rise exactly H_A edges later.
    // The wait is bounded.
    rise_at = -1;
    for (int k = 1; k <= int'(H_A) + 10; k++) begin
      cycle(1'b0);
      if (clk_div_100 === 1'b1) begin
        rise_at = k;
        break;
      end
    end
    check_int("rise_after_mid_reset", rise_at, H_A);

    // Continue through a full clk_div_200 period after the restart.
    for (int i = 0; i < 220; i++) cycle(1'b0);

    // Final reset hold.
    for (int i = 0; i < 3; i++) cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pulse
